// File: rtl/rc5_key_expand_if.sv
// RC5 key-expansion bus: key load, start control, S-table read ports, status.
// Latency: none of its own; it only bundles signals.
// Backpressure: none; reads are always serviced, and key writes and start
// requests are ignored while an expansion is running.
// Ports: master = key loader / cipher side, slave = rc5_key_expand.
interface rc5_key_expand_if #(
  parameter int W = 32,
  parameter int R = 12,
  parameter int C = 4
);
  localparam int T        = 2 * (R + 1);
  localparam int T_LENGTH = $clog2(T);
  localparam int KA       = (C > 1) ? $clog2(C) : 1;

  logic                iKey_we;
  logic [KA-1:0]       iKey_addr;
  logic [W-1:0]        iKey_word;
  logic                iStart;
  logic [T_LENGTH-1:0] iS_address1;
  logic [T_LENGTH-1:0] iS_address2;
  logic [W-1:0]        oS_sub_i1;
  logic [W-1:0]        oS_sub_i2;
  logic                oBusy;
  logic                oValid;
  logic                oDone;

  modport master (
    output iKey_we, iKey_addr, iKey_word, iStart, iS_address1, iS_address2,
    input  oS_sub_i1, oS_sub_i2, oBusy, oValid, oDone
  );

  modport slave (
    input  iKey_we, iKey_addr, iKey_word, iStart, iS_address1, iS_address2,
    output oS_sub_i1, oS_sub_i2, oBusy, oValid, oDone
  );
endinterface

// File: rtl/rc5_key_expand.sv
// RC5 key expansion: loads a C-word key and builds the expanded table S[0..T-1].
// Latency: oDone is high in the cycle after edge start+T+2N. S reads take 1 cycle.
// Backpressure: none; key writes and iStart are ignored while oBusy is high.
// Ports: clk, rst (sync, active-high), bus (slave modport of rc5_key_expand_if).
module rc5_key_expand #(
  parameter int W = 32,
  parameter int R = 12,
  parameter int C = 4
) (
  input logic             clk,
  input logic             rst,
  rc5_key_expand_if.slave bus
);
  localparam int T        = 2 * (R + 1);
  localparam int N        = 3 * ((T > C) ? T : C);
  localparam int T_LENGTH = $clog2(T);
  localparam int KA       = (C > 1) ? $clog2(C) : 1;
  localparam int LW       = $clog2(W);
  localparam int KW       = $clog2(N);

  localparam logic [63:0] P64 = (W == 16) ? 64'h0000_0000_0000_B7E1 :
                                (W == 32) ? 64'h0000_0000_B7E1_5163 :
                                            64'hB7E1_5162_8AED_2A6B;
  localparam logic [63:0] Q64 = (W == 16) ? 64'h0000_0000_0000_9E37 :
                                (W == 32) ? 64'h0000_0000_9E37_79B9 :
                                            64'h9E37_79B9_7F4A_7C15;
  localparam logic [W-1:0] P = P64[W-1:0];
  localparam logic [W-1:0] Q = Q64[W-1:0];

  localparam logic [T_LENGTH-1:0] I_LAST = T_LENGTH'(T - 1);
  localparam logic [T_LENGTH-1:0] I_ONE  = T_LENGTH'(1);
  localparam logic [KA-1:0]       J_LAST = KA'(C - 1);
  localparam logic [KA-1:0]       J_ONE  = KA'(1);
  localparam logic [KW-1:0]       K_LAST = KW'(N - 1);
  localparam logic [KW-1:0]       K_ONE  = KW'(1);

  typedef enum logic [2:0] {IDLE, INIT, MIX_A, MIX_B, DONE} state_t;

  state_t              state_q;
  logic [W-1:0]        key_q [C];
  logic [W-1:0]        l_q   [C];
  logic [W-1:0]        s_q   [T];
  logic [W-1:0]        a_q, b_q;
  logic [T_LENGTH-1:0] i_q;
  logic [KA-1:0]       j_q;
  logic [KW-1:0]       pass_q;
  logic                busy_q, valid_q, done_q;
  logic [W-1:0]        rd1_q, rd2_q;

  logic [W-1:0] x_d, y_d, ab_d;

  // Rotate left; amount already reduced to log2(W) bits.
  function automatic logic [W-1:0] rotl(input logic [W-1:0] x, input logic [LW-1:0] n);
    logic [2*W-1:0] t;
    t = {x, x} << n;
    return t[2*W-1:W];
  endfunction

  // x_d is used in MIX_A; y_d in MIX_B, where a_q already holds the new A.
  always_comb begin
    x_d  = rotl(s_q[i_q] + a_q + b_q, LW'(3));
    ab_d = a_q + b_q;
    y_d  = rotl(l_q[j_q] + ab_d, ab_d[LW-1:0]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      i_q     <= '0;
      j_q     <= '0;
      pass_q  <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      rd1_q   <= '0;
      rd2_q   <= '0;
      for (int n = 0; n < T; n++) s_q[n] <= '0;
      for (int n = 0; n < C; n++) begin
        key_q[n] <= '0;
        l_q[n]   <= '0;
      end
    end else begin
      // Read ports run every cycle regardless of state.
      rd1_q <= (int'(bus.iS_address1) < T) ? s_q[bus.iS_address1] : '0;
      rd2_q <= (int'(bus.iS_address2) < T) ? s_q[bus.iS_address2] : '0;

      case (state_q)
        IDLE: begin
          if (bus.iKey_we) begin
            if (int'(bus.iKey_addr) < C) key_q[bus.iKey_addr] <= bus.iKey_word;
            valid_q <= 1'b0;
          end
          if (bus.iStart) begin
            state_q <= INIT;
            i_q     <= '0;
            busy_q  <= 1'b1;
            valid_q <= 1'b0;
          end
        end

        INIT: begin
          s_q[i_q] <= (i_q == '0) ? P : s_q[i_q - I_ONE] + Q;
          // Working copy taken on the first INIT cycle, so a key write that
          // landed on the start edge is already visible in key_q here.
          if (i_q == '0) begin
            for (int n = 0; n < C; n++) l_q[n] <= key_q[n];
          end
          if (i_q == I_LAST) begin
            state_q <= MIX_A;
            i_q     <= '0;
            j_q     <= '0;
            pass_q  <= '0;
            a_q     <= '0;
            b_q     <= '0;
          end else begin
            i_q <= i_q + I_ONE;
          end
        end

        MIX_A: begin
          s_q[i_q] <= x_d;
          a_q      <= x_d;
          state_q  <= MIX_B;
        end

        MIX_B: begin
          l_q[j_q] <= y_d;
          b_q      <= y_d;
          i_q      <= (i_q == I_LAST) ? '0 : i_q + I_ONE;
          j_q      <= (j_q == J_LAST) ? '0 : j_q + J_ONE;
          pass_q   <= pass_q + K_ONE;
          if (pass_q == K_LAST) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            valid_q <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            state_q <= MIX_A;
          end
        end

        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.oS_sub_i1 = rd1_q;
  assign bus.oS_sub_i2 = rd2_q;
  assign bus.oBusy     = busy_q;
  assign bus.oValid    = valid_q;
  assign bus.oDone     = done_q;
endmodule

// File: doc/rc5_key_expand.md
# rc5_key_expand

RC5 key-expansion engine sitting directly upstream of the RC5 cipher core. It takes a secret key loaded word-by-word and computes the expanded key table S[0..T-1] using the standard RC5 magic-constant init and 3·max(T,C) mixing passes. It holds S internally and serves the cipher's two S-table read ports with one-cycle registered latency, matching the cipher's address/wait/read sequence.

## Interface
- W, 32, word width; legal values 16, 32, 64 (selects P/Q constants).
- R, 12, round count; T = 2·(R+1) table words.
- C, 4, key length in W-bit words (b = C·W/8 bytes).
- T_LENGTH, $clog2(T), S address width; KA = $clog2(C) (min 1), key address width.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- iKey_we  in  1  key word write strobe.
- iKey_addr  in  KA  key word index (word 0 = least significant key bytes, RC5 little-endian).
- iKey_word  in  W  key word data.
- iStart  in  1  begin expansion of the currently loaded key.
- iS_address1, iS_address2  in  T_LENGTH  S-table read addresses from the cipher.
- oS_sub_i1, oS_sub_i2  out  W  registered S[iS_address1], S[iS_address2].
- oBusy  out  1  expansion in progress.
- oValid  out  1  S table holds a complete expansion of the current key.
- oDone  out  1  one-cycle pulse at expansion completion.

## Operation
- Constants: W=16 P=0xB7E1 Q=0x9E37; W=32 P=0xB7E15163 Q=0x9E3779B9; W=64 P=0xB7E151628AED2A6B Q=0x9E3779B97F4A7C15.
- Storage: key regs K[0..C-1], working L[0..C-1], S[0..T-1], accumulators A, B, indices i (mod T), j (mod C), pass counter k. All cleared to 0 on rst.
- Key load: iKey_we in IDLE writes K[iKey_addr]; clears oValid. Writes while busy are ignored. K is never modified by expansion, so repeated iStart without reload reproduces the same S.
- States: IDLE, INIT, MIX_A, MIX_B, DONE.
- IDLE: iStart=1 -> INIT, idx=0, oBusy=1, oValid=0. Otherwise hold.
- INIT (T cycles): S[idx] <= (idx==0) ? P : S[idx-1]+Q (mod 2^W); if idx<C, L[idx] <= K[idx]. After idx=T-1 -> MIX_A with i=j=k=0, A=B=0.
- MIX_A: x = rotl(S[i]+A+B, 3); S[i] <= x; A <= x -> MIX_B.
- MIX_B: y = rotl(L[j]+A+B, (A+B) mod W), A is the value written in MIX_A; L[j] <= y; B <= y; i <= (i+1) mod T; j <= (j+1) mod C; k <= k+1. If k == N-1 (N = 3·max(T,C)) -> DONE, else -> MIX_A.
- DONE: oDone=1 for this one cycle, oValid <= 1, oBusy <= 0 -> IDLE.
- All additions modulo 2^W; rotate amount uses low log2(W) bits only.
- Read ports: every cycle oS_sub_iN <= S[iS_addressN]; address ≥ T returns 0. Reads are always serviced; data during oBusy is undefined-in-content but still deterministic (current S register contents).
- iStart while oBusy is ignored. iStart in IDLE with oValid=1 restarts expansion and drops oValid.

## Timing
- Reset values: oS_sub_i1=0, oS_sub_i2=0, oBusy=0, oValid=0, oDone=0, state IDLE.
- rst mid-expansion: abort next edge to IDLE, all outputs and storage to reset values; partial S discarded.
- Latency: iStart sampled at edge e0 -> oDone high in the cycle after edge e0+T+2N, oValid high from that same edge. Defaults (T=26, N=78): edge e0+182.
- oDone is exactly one cycle wide; oBusy falls on the same edge oDone rises.
- Read latency: address presented before edge e -> data valid after edge e (1 cycle); back-to-back addresses give back-to-back data; both ports independent, same address on both ports legal.
- Key write and iStart in the same IDLE cycle: key write lands, expansion uses the new word.

## Test plan
- Reset: assert rst 2 cycles, read addresses 0 and 25 -> oS_sub_i1=oS_sub_i2=0, oValid=0, oBusy=0.
- Zero key, defaults: load K=0, iStart -> oDone exactly at e0+182; all 26 S words match software RC5-32/12/16 model; chained cipher with pt A=B=0 gives A=0xEEDBA521, B=0x6D8F4B15.
- Key 0x91 5F 46 19 BE 41 B2 51 63 55 A5 01 10 A9 CE 91 -> S matches model; re-iStart without reload reproduces identical S.
- Abort: iStart, rst at cycle 100 -> idle, oValid=0; then iStart completes normally at e0+182 with correct S.
- Busy guards: iStart and iKey_we during expansion -> ignored, result equals run without them; read address 26..31 -> 0.
- W=16 and W=64 builds, R=12, C=4 zero key -> S matches model; S[0] before mixing equals P (checked by probing state INIT end).
